// File: rtl/mio_pkg.sv
// Shared types and address map for the memory/IO responder.
// Holds the FSM state encoding and the request bundle.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  localparam logic [31:0] LED_ADDR  = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;
  localparam logic [3:0]  IO_REGION = 4'hF;

endpackage

// File: rtl/mio_ram.sv
// Single-port word RAM for the responder.
// Synchronous write, combinational read, no reset.
module mio_ram #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mio_responder.sv
// Bus responder: RAM, LED register and cycle counter.
// One request in flight; fixed wait states before the reply.
module mio_responder
  import mio_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_WORDS   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  output logic        bus_err,
  output logic [7:0]  led_out
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t      state, state_nx;
  req_t        req;
  logic [3:0]  wcnt, wcnt_nx;
  logic [31:0] cnt;
  logic [7:0]  led;
  logic [31:0] ram_rdata;
  logic        is_io, is_led, is_cnt;
  logic        err, resp, commit, ram_we;

  assign is_io  = req.addr[31:28] == IO_REGION;
  assign is_led = req.addr == LED_ADDR;
  assign is_cnt = req.addr == CNT_ADDR;
  assign err    = (|req.addr[1:0])
                | (is_io & ~is_led & ~is_cnt);
  assign resp   = state == RESP;
  assign commit = resp & req.we & ~err;
  assign ram_we = commit & ~is_io;

  mio_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (req.addr[AW+1:2]),
    .wdata (req.data),
    .rdata (ram_rdata)
  );

  // state, wait counter and captured request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wcnt  <= '0;
      req   <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (state == IDLE && CPU_MIO)
        req <= '{we: mem_w, addr: Addr_in, data: Data_in};
    end
  end

  // next state and wait countdown
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    unique case (state)
      IDLE: begin
        if (CPU_MIO) begin
          wcnt_nx  = WC;
          state_nx = (WC == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        wcnt_nx = wcnt - 4'd1;
        if (wcnt == 4'd1) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // LED register and free-running counter; a clear beats the increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= '0;
      cnt <= '0;
    end else begin
      if (commit && is_led) led <= req.data[7:0];
      if (commit && is_cnt) cnt <= '0;
      else                  cnt <= cnt + 32'd1;
    end
  end

  // read data only on a clean read reply
  always_comb begin
    Data_out = '0;
    if (resp && !req.we && !err) begin
      unique case (1'b1)
        is_led: Data_out = {24'd0, led};
        is_cnt: Data_out = cnt;
        !is_io: Data_out = ram_rdata;
      endcase
    end
  end

  assign MIO_ready = resp;
  assign bus_err   = resp & err;
  assign led_out   = led;

endmodule

// File: doc/mio_responder.md
MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, the number of wait states inserted before each response (range 0..15).
REQ-002 SHALL have parameter RAM_WORDS, default 256, the depth of the internal 32-bit word RAM (power of two, max 1024).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CPU_MIO  input  1  bus request valid from the CPU.
REQ-006 SHALL have port mem_w  input  1  1 = write, 0 = read; sampled with CPU_MIO.
REQ-007 SHALL have port Addr_in  input  32  byte address of the request.
REQ-008 SHALL have port Data_in  input  32  write data from the CPU.
REQ-009 SHALL have port Data_out  output  32  read data to the CPU; valid only while MIO_ready=1.
REQ-010 SHALL have port MIO_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port bus_err  output  1  one-cycle pulse, coincident with MIO_ready, flagging an erroneous request.
REQ-012 SHALL have port led_out  output  8  LED register contents.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE with CPU_MIO=1 SHALL latch mem_w, Addr_in and Data_in, load the wait counter with WAIT_CYCLES, and go to WAIT (or to RESP if WAIT_CYCLES=0).
REQ-015 WAIT SHALL decrement the wait counter each cycle and go to RESP when it reaches 1 (WAIT_CYCLES cycles spent in WAIT).
REQ-016 RESP SHALL last exactly one cycle with MIO_ready=1, then return to IDLE unconditionally.
REQ-017 Latency SHALL be WAIT_CYCLES+1 cycles from the capture edge to the MIO_ready cycle.
REQ-018 A new request SHALL be accepted only in IDLE, so back-to-back requests have at least one idle cycle between MIO_ready and the next capture.
REQ-019 Input changes after capture, including CPU_MIO deassertion, SHALL NOT affect or abort the transaction in flight.
REQ-020 Decode: Addr[31:28]!=4'hF SHALL select RAM word Addr[log2(RAM_WORDS)+1:2], with upper address bits ignored (aliasing).
REQ-021 Decode: 0xF000_0000 SHALL select the LED register (R/W; writes store Data_in[7:0]; reads return zero-extended value).
REQ-022 Decode: 0xF000_0004 SHALL select a free-running 32-bit cycle counter (reads return current value; any write clears it to 0).
REQ-023 The cycle counter SHALL increment every cycle out of reset and wrap 0xFFFF_FFFF -> 0; a write in the same cycle SHALL win, giving 0.
REQ-024 A write SHALL commit only on the RESP edge; read data SHALL be sampled in RESP.
REQ-025 Addr[1:0]!=0, or any unmapped 0xFxxx_xxxx address, SHALL assert bus_err in RESP, commit no write, and return Data_out=0.
REQ-026 Data_out SHALL be 0 whenever MIO_ready=0.

Reset
REQ-027 reset=0 SHALL asynchronously force state IDLE, MIO_ready=0, bus_err=0, Data_out=0, led_out=0, cycle counter=0 and wait counter=0.
REQ-028 Reset during WAIT or RESP SHALL abort the transaction with no write committed and no MIO_ready pulse.
REQ-029 RAM contents SHALL NOT be reset.

Structure
REQ-030 Package mio_pkg SHALL hold the state enum, LED_ADDR=0xF000_0000, CNT_ADDR=0xF000_0004 and IO_REGION=4'hF.
REQ-031 The RAM SHALL be a sub-module mio_ram: single port, synchronous write, combinational read, RAM_WORDS x 32.

Verification
REQ-032 Scenario: write 0x1234_5678 to 0x0000_0010, then read 0x0000_0010 -> MIO_ready exactly 3 cycles after each capture edge, read Data_out=0x1234_5678, bus_err=0.
REQ-033 Scenario: WAIT_CYCLES=0, write 0xA5 to 0xF000_0000 -> MIO_ready 1 cycle after capture, led_out=0xA5 after RESP edge; read returns 0x0000_00A5.
REQ-034 Scenario: write to 0xF000_0004, then read it 10 cycles later -> value equals elapsed cycles (10 + latency), confirming clear-wins and counting.
REQ-035 Scenario: write to 0x0000_0012 and 0xF000_0100 -> bus_err=1 with MIO_ready; RAM and LED unchanged; Data_out=0.
REQ-036 Scenario: drop CPU_MIO and change Addr_in during WAIT -> original transaction completes to its latched address.
REQ-037 Scenario: assert reset mid-WAIT of a write -> no MIO_ready; target word retains its old value; outputs at reset values.
